// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and widths for the two-requester memory arbiter.
//   arb_state_t : arbiter FSM encoding (ARB_IDLE, ARB_INSTR, ARB_DATA)
//   WORD_W      : data word width on every port
//   SEL_W       : byte-enable width
//   REQ_ADDR_W  : address field width of the latched request; the top
//                 module's ADDR_WIDTH may not exceed it
//   mem_req_t   : request captured at grant and replayed to memory
package mem_arb_pkg;

    localparam int WORD_W     = 32;
    localparam int SEL_W      = 4;
    localparam int REQ_ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_INSTR = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic                  wr_en;
        logic [WORD_W-1:0]     wr_data;
        logic [SEL_W-1:0]      wr_sel;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one pipelined Wishbone memory port between the fetch stage
//   (req/ack handshake) and the LSU (pipelined Wishbone). One transaction
//   is outstanding at a time; data wins over fetch.
//
//   Optional feature macro: ARB_STARVE_GUARD_EN
//     defined   -> a saturating counter of consecutive data grants taken
//                  while fetch waits; at STARVE_LIMIT the next grant goes
//                  to fetch.
//     undefined -> strict data priority, no counter.
//
//   Ports
//     clk, rst_n                       clock, async active-low reset
//     instr_addr, instr_stb            fetch request (level, held to ack)
//     instr_ack, instr                 one-cycle fetch ack + word
//     d_cyc, d_stb, d_wr_en, d_addr,
//     d_wr_data, d_wr_sel              LSU Wishbone request
//     d_ack, d_stall, d_rd_data        LSU Wishbone response
//     m_cyc, m_stb, m_wr_en, m_addr,
//     m_wr_data, m_wr_sel              memory-side Wishbone request
//     m_ack, m_stall, m_rd_data        memory-side Wishbone response
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ARB_IDLE  | no transaction; arbitrate and latch the winning request
//   ARB_INSTR | fetch transaction on the memory port, waiting for m_ack
//   ARB_DATA  | LSU transaction on the memory port, waiting for m_ack
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_stb,
    output logic                  instr_ack,
    output logic [WORD_W-1:0]     instr,

    input  logic                  d_cyc,
    input  logic                  d_stb,
    input  logic                  d_wr_en,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_W-1:0]     d_wr_data,
    input  logic [SEL_W-1:0]      d_wr_sel,
    output logic                  d_ack,
    output logic                  d_stall,
    output logic [WORD_W-1:0]     d_rd_data,

    output logic                  m_cyc,
    output logic                  m_stb,
    output logic                  m_wr_en,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [WORD_W-1:0]     m_wr_data,
    output logic [SEL_W-1:0]      m_wr_sel,
    input  logic                  m_ack,
    input  logic                  m_stall,
    input  logic [WORD_W-1:0]     m_rd_data
);

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("mem_arbiter: STARVE_LIMIT must be at least 1");
    end
    if (ADDR_WIDTH > REQ_ADDR_W) begin : g_addr_check
        $error("mem_arbiter: ADDR_WIDTH exceeds the latched request address field");
    end

    arb_state_t state;
    mem_req_t   req;
    logic       d_live;       // LSU still holds its cycle for the current data transaction
    logic       data_req;
    logic       force_instr;
    logic       grant_data;
    logic       grant_instr;

    assign data_req    = d_cyc & d_stb;
    assign grant_data  = (state == ARB_IDLE) && data_req && !force_instr;
    assign grant_instr = (state == ARB_IDLE) && instr_stb && !grant_data;

    // The LSU request is only ever accepted in the granting IDLE cycle;
    // gating with rst_n keeps d_stall high while the block is held in reset.
    assign d_stall = !(rst_n && grant_data);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    assign force_instr = instr_stb && (starve_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!instr_stb || grant_instr) begin
            starve_cnt <= '0;
        end else if (grant_data && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_instr = 1'b0;
`endif

    assign m_addr    = ADDR_WIDTH'(req.addr);
    assign m_wr_en   = req.wr_en;
    assign m_wr_data = req.wr_data;
    assign m_wr_sel  = req.wr_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            req       <= '0;
            d_live    <= 1'b0;
            m_cyc     <= 1'b0;
            m_stb     <= 1'b0;
            instr_ack <= 1'b0;
            instr     <= '0;
            d_ack     <= 1'b0;
            d_rd_data <= '0;
        end else begin
            instr_ack <= 1'b0;
            d_ack     <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (grant_data) begin
                        state  <= ARB_DATA;
                        req    <= '{addr:    REQ_ADDR_W'(d_addr),
                                    wr_en:   d_wr_en,
                                    wr_data: d_wr_data,
                                    wr_sel:  d_wr_sel};
                        m_cyc  <= 1'b1;
                        m_stb  <= 1'b1;
                        d_live <= 1'b1;
                    end else if (grant_instr) begin
                        state  <= ARB_INSTR;
                        req    <= '{addr:    REQ_ADDR_W'(instr_addr),
                                    wr_en:   1'b0,
                                    wr_data: '0,
                                    wr_sel:  '1};
                        m_cyc  <= 1'b1;
                        m_stb  <= 1'b1;
                    end
                end
                ARB_INSTR, ARB_DATA: begin
                    // Strobe is held only until memory accepts it.
                    if (!m_stall) begin
                        m_stb <= 1'b0;
                    end
                    // An abandoned LSU cycle still lets memory finish, silently.
                    if ((state == ARB_DATA) && !d_cyc) begin
                        d_live <= 1'b0;
                    end
                    if (m_ack) begin
                        m_cyc <= 1'b0;
                        m_stb <= 1'b0;
                        state <= ARB_IDLE;
                        if (state == ARB_INSTR) begin
                            instr     <= m_rd_data;
                            instr_ack <= 1'b1;
                        end else begin
                            d_rd_data <= m_rd_data;
                            d_ack     <= d_live && d_cyc;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_addr;
    logic        instr_stb;
    logic        instr_ack;
    logic [31:0] instr;
    logic        d_cyc, d_stb, d_wr_en;
    logic [31:0] d_addr, d_wr_data;
    logic [3:0]  d_wr_sel;
    logic        d_ack, d_stall;
    logic [31:0] d_rd_data;
    logic        m_cyc, m_stb, m_wr_en;
    logic [31:0] m_addr, m_wr_data;
    logic [3:0]  m_wr_sel;
    logic        m_ack, m_stall;
    logic [31:0] m_rd_data;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 4;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_addr(instr_addr), .instr_stb(instr_stb), .instr_ack(instr_ack), .instr(instr),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_wr_en(d_wr_en), .d_addr(d_addr),
        .d_wr_data(d_wr_data), .d_wr_sel(d_wr_sel), .d_ack(d_ack), .d_stall(d_stall),
        .d_rd_data(d_rd_data),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_wr_en(m_wr_en), .m_addr(m_addr),
        .m_wr_data(m_wr_data), .m_wr_sel(m_wr_sel), .m_ack(m_ack), .m_stall(m_stall),
        .m_rd_data(m_rd_data)
    );

    // ---------------- memory model and reference memory ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  sel;
    } acc_t;

    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    acc_t        acc_q[$];
    bit          mdl_en = 1'b1;
    int          stall_cfg = 0;
    int          stall_left = 0;
    bit          in_stb = 1'b0;
    bit          ack_next = 1'b0;
    logic [31:0] rd_val = '0;
    int          stb_cnt = 0;
    int          cyc_cnt = 0;
    int          overlap = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Slave: stalls each new strobe stall_cfg cycles, acks one cycle after accept.
    initial begin
        logic [31:0] old;
        m_ack = 1'b0; m_stall = 1'b0; m_rd_data = '0;
        forever begin
            @(negedge clk);
            if (mdl_en) begin
                m_ack = 1'b0;
                if (ack_next) begin
                    m_ack = 1'b1; m_rd_data = rd_val; ack_next = 1'b0;
                end
                if (m_cyc && m_stb) begin
                    if (!in_stb) begin in_stb = 1'b1; stall_left = stall_cfg; end
                    if (stall_left > 0) begin
                        m_stall = 1'b1; stall_left--;
                    end else begin
                        m_stall = 1'b0; in_stb = 1'b0; ack_next = 1'b1;
                        acc_q.push_back('{m_addr, m_wr_en, m_wr_data, m_wr_sel});
                        old = mem_rd(m_addr);
                        if (m_wr_en) begin
                            mem[m_addr] = merge(old, m_wr_data, m_wr_sel);
                            rd_val = 32'h0;
                        end else begin
                            rd_val = old;
                        end
                    end
                end else begin
                    m_stall = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_stb) stb_cnt++;
        if (m_cyc) cyc_cnt++;
        if (instr_ack && d_ack) overlap++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helper (no checking) ----------------
    task automatic run_pair(input bit do_i, input logic [31:0] ia, input bit do_d, input bit we,
                            input logic [31:0] da, input logic [31:0] wd, input logic [3:0] sel,
                            output int i_lat, output int d_lat,
                            output logic [31:0] i_dat, output logic [31:0] d_dat,
                            output int n_iack, output int n_dack, output int n_dsl,
                            output byte first);
        int   cyc = 0;
        logic st;
        i_lat = -1; d_lat = -1; i_dat = '0; d_dat = '0;
        n_iack = 0; n_dack = 0; n_dsl = 0; first = "-";
        instr_addr = ia; instr_stb = do_i;
        d_addr = da; d_wr_en = we; d_wr_data = wd; d_wr_sel = sel;
        d_cyc = do_d; d_stb = do_d;
        while (cyc < 40 && !((!do_i || i_lat >= 0) && (!do_d || d_lat >= 0))) begin
            @(negedge clk); st = d_stall; if (!st) n_dsl++;
            @(posedge clk); #1; cyc++;
            if (d_stb && !st) d_stb = 1'b0;
            if (instr_ack) begin
                n_iack++;
                if (i_lat < 0) begin
                    i_lat = cyc; i_dat = instr;
                    if (first == "-") first = "I";
                end
                instr_stb = 1'b0;
            end
            if (d_ack) begin
                n_dack++;
                if (d_lat < 0) begin
                    d_lat = cyc; d_dat = d_rd_data;
                    if (first == "-") first = "D";
                end
                d_cyc = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk); if (!d_stall) n_dsl++;
            @(posedge clk); #1;
            if (instr_ack) n_iack++;
            if (d_ack) n_dack++;
        end
        instr_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({instr_ack, instr, d_ack, d_rd_data, m_cyc, m_stb, m_wr_en, m_addr, m_wr_data, m_wr_sel} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got m_cyc=%b m_stb=%b m_addr=%h m_wr_sel=%h instr=%h d_rd_data=%h acks=%b%b want all zero",
                     m_cyc, m_stb, m_addr, m_wr_sel, instr, d_rd_data, instr_ack, d_ack);
        end
        n_cmp++;
        if (d_stall !== 1'b1) begin n_bad++; $display("FAIL reset_d_stall: got %b want 1", d_stall); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (m_cyc !== 1'b0) begin n_bad++; $display("FAIL reset_idle_m_cyc: got %b want 0", m_cyc); end
    endtask

    task automatic test_lone_fetch;
        int il, dl, ni, nd, ns; logic [31:0] id, dd; byte f;
        stall_cfg = 0; acc_q.delete();
        run_pair(1'b1, 32'h1000, 1'b0, 1'b0, '0, '0, '0, il, dl, id, dd, ni, nd, ns, f);
        n_cmp++; if (il !== 3) begin n_bad++; $display("FAIL fetch_latency: got %0d want 3", il); end
        n_cmp++; if (id !== 32'h0050_0093) begin n_bad++; $display("FAIL fetch_data: got %h want 00500093", id); end
        n_cmp++; if (ni !== 1 || nd !== 0) begin n_bad++; $display("FAIL fetch_ack_pulses: got instr=%0d data=%0d want 1/0", ni, nd); end
        n_cmp++;
        if (acc_q.size() !== 1 || acc_q[0].addr !== 32'h1000 || acc_q[0].we !== 1'b0 || acc_q[0].sel !== 4'hF) begin
            n_bad++;
            $display("FAIL fetch_mem_side: got n=%0d addr=%h we=%b sel=%h want 1 1000 0 f",
                     acc_q.size(), acc_q.size() > 0 ? acc_q[0].addr : 32'h0,
                     acc_q.size() > 0 ? acc_q[0].we : 1'b0, acc_q.size() > 0 ? acc_q[0].sel : 4'h0);
        end
    endtask

    task automatic test_lone_write;
        int il, dl, ni, nd, ns; logic [31:0] id, dd; byte f;
        stall_cfg = 0; acc_q.delete();
        ref_mem[32'h200] = merge(ref_rd(32'h200), 32'hDEAD_BEEF, 4'b0011);
        run_pair(1'b0, '0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, il, dl, id, dd, ni, nd, ns, f);
        n_cmp++; if (ns !== 1) begin n_bad++; $display("FAIL write_d_stall_low_cycles: got %0d want 1", ns); end
        n_cmp++; if (dl !== 3 || nd !== 1) begin n_bad++; $display("FAIL write_ack: got lat=%0d pulses=%0d want 3/1", dl, nd); end
        n_cmp++;
        if (acc_q.size() !== 1 || acc_q[0].addr !== 32'h200 || acc_q[0].we !== 1'b1 ||
            acc_q[0].wd !== 32'hDEAD_BEEF || acc_q[0].sel !== 4'b0011) begin
            n_bad++;
            $display("FAIL write_mem_side: got n=%0d addr=%h we=%b wd=%h sel=%h want 1 200 1 deadbeef 3",
                     acc_q.size(), acc_q.size() > 0 ? acc_q[0].addr : 32'h0, acc_q.size() > 0 ? acc_q[0].we : 1'b0,
                     acc_q.size() > 0 ? acc_q[0].wd : 32'h0, acc_q.size() > 0 ? acc_q[0].sel : 4'h0);
        end
        n_cmp++;
        if (mem_rd(32'h200) !== ref_rd(32'h200)) begin
            n_bad++; $display("FAIL write_mem_content: got %h want %h", mem_rd(32'h200), ref_rd(32'h200));
        end
    endtask

    task automatic test_simultaneous;
        int il, dl, ni, nd, ns; logic [31:0] id, dd; byte f;
        stall_cfg = 0; acc_q.delete();
        run_pair(1'b1, 32'h1004, 1'b1, 1'b0, 32'h300, '0, 4'hF, il, dl, id, dd, ni, nd, ns, f);
        n_cmp++; if (f !== "D") begin n_bad++; $display("FAIL simul_order: got %c first want D", f); end
        n_cmp++; if (dl !== 3 || il !== 6) begin n_bad++; $display("FAIL simul_latency: got d=%0d i=%0d want 3/6", dl, il); end
        n_cmp++; if (dd !== ref_rd(32'h300)) begin n_bad++; $display("FAIL simul_d_data: got %h want %h", dd, ref_rd(32'h300)); end
        n_cmp++; if (id !== ref_rd(32'h1004)) begin n_bad++; $display("FAIL simul_i_data: got %h want %h", id, ref_rd(32'h1004)); end
        n_cmp++;
        if (acc_q.size() !== 2 || acc_q[0].addr !== 32'h300 || acc_q[1].addr !== 32'h1004) begin
            n_bad++; $display("FAIL simul_mem_order: got n=%0d want 2 accesses 300 then 1004", acc_q.size());
        end
    endtask

    task automatic test_stall;
        int il, dl, ni, nd, ns, s0, c0; logic [31:0] id, dd; byte f;
        stall_cfg = 2; acc_q.delete();
        s0 = stb_cnt; c0 = cyc_cnt;
        run_pair(1'b1, 32'h1008, 1'b0, 1'b0, '0, '0, '0, il, dl, id, dd, ni, nd, ns, f);
        n_cmp++; if (stb_cnt - s0 !== 3) begin n_bad++; $display("FAIL stall_stb_cycles: got %0d want 3", stb_cnt - s0); end
        n_cmp++; if (cyc_cnt - c0 !== 4) begin n_bad++; $display("FAIL stall_cyc_cycles: got %0d want 4", cyc_cnt - c0); end
        n_cmp++; if (il !== 5) begin n_bad++; $display("FAIL stall_latency: got %0d want 5", il); end
        n_cmp++; if (id !== ref_rd(32'h1008)) begin n_bad++; $display("FAIL stall_data: got %h want %h", id, ref_rd(32'h1008)); end
        stall_cfg = 0;
    endtask

    task automatic test_dcyc_drop;
        int   n_dack = 0, n_mack = 0;
        logic st = 1'b1;
        stall_cfg = 3; acc_q.delete();
        d_addr = 32'h500; d_wr_en = 1'b0; d_wr_data = '0; d_wr_sel = 4'hF;
        d_cyc = 1'b1; d_stb = 1'b1;
        for (int c = 0; c < 20 && st; c++) begin
            @(negedge clk); st = d_stall;
            @(posedge clk); #1;
        end
        d_stb = 1'b0;
        @(posedge clk); #1;
        d_cyc = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (m_ack) n_mack++;
            if (d_ack) n_dack++;
            @(posedge clk); #1;
        end
        n_cmp++; if (st !== 1'b0) begin n_bad++; $display("FAIL drop_granted: got d_stall=%b want 0 at grant", st); end
        n_cmp++; if (n_mack !== 1) begin n_bad++; $display("FAIL drop_mem_completes: got %0d m_ack want 1", n_mack); end
        n_cmp++; if (n_dack !== 0) begin n_bad++; $display("FAIL drop_d_ack_suppressed: got %0d want 0", n_dack); end
        n_cmp++; if (m_cyc !== 1'b0) begin n_bad++; $display("FAIL drop_m_cyc_released: got %b want 0", m_cyc); end
        stall_cfg = 0;
    endtask

    task automatic test_starve;
        byte  exp_q[$];
        byte  got_q[$];
        int   cnt = 0, d_left = 6, issued = 0, cyc = 0;
        bit   i_pend = 1'b1;
        logic st;
        // Reference: data wins unless the guard sees LIMIT consecutive data grants.
        while (d_left > 0 || i_pend) begin
            if (i_pend && (d_left == 0 || (GUARD && cnt == LIMIT))) begin
                exp_q.push_back("I"); i_pend = 1'b0; cnt = 0;
            end else begin
                exp_q.push_back("D"); d_left--;
                if (i_pend && cnt < LIMIT) cnt++;
            end
        end
        stall_cfg = 0;
        instr_addr = 32'h3000; instr_stb = 1'b1;
        d_wr_en = 1'b0; d_wr_sel = 4'hF; d_wr_data = '0; d_addr = 32'h600;
        d_cyc = 1'b1; d_stb = 1'b1;
        while (got_q.size() < 7 && cyc < 100) begin
            @(negedge clk); st = d_stall;
            @(posedge clk); #1; cyc++;
            if (d_stb && !st) begin d_stb = 1'b0; issued++; end
            if (d_ack) begin
                got_q.push_back("D");
                if (issued < 6) begin d_addr = 32'h600 + 32'(4 * issued); d_stb = 1'b1; end
                else d_cyc = 1'b0;
            end
            if (instr_ack) begin got_q.push_back("I"); instr_stb = 1'b0; end
        end
        d_cyc = 1'b0; d_stb = 1'b0; instr_stb = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL starve_ack_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            byte g;
            g = (k < got_q.size()) ? got_q[k] : "-";
            n_cmp++;
            if (g !== exp_q[k]) begin
                n_bad++; $display("FAIL starve_order[%0d]: got %c want %c", k, g, exp_q[k]);
            end
        end
    endtask

    task automatic test_random;
        int il, dl, ni, nd, ns, s, kind; logic [31:0] id, dd, ia, da, wd, exp_d; logic [3:0] sel;
        bit di, dd_en, we; byte f;
        for (int it = 0; it < 16; it++) begin
            kind  = $urandom_range(0, 3);
            s     = $urandom_range(0, 2);
            ia    = 32'h2000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            da    = 32'h400 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            wd    = $urandom;
            sel   = 4'($urandom_range(1, 15));
            di    = (kind == 0) || (kind == 3);
            dd_en = (kind != 0);
            we    = (kind == 1) || ((kind == 3) && $urandom_range(0, 1) == 1);
            exp_d = ref_rd(da);
            if (dd_en && we) ref_mem[da] = merge(ref_rd(da), wd, sel);
            stall_cfg = s; acc_q.delete();
            run_pair(di, ia, dd_en, we, da, wd, sel, il, dl, id, dd, ni, nd, ns, f);
            if (di) begin
                n_cmp++;
                if (il !== (dd_en ? 6 + 2 * s : 3 + s) || id !== ref_rd(ia) || ni !== 1) begin
                    n_bad++;
                    $display("FAIL rand%0d_fetch: got lat=%0d data=%h pulses=%0d want lat=%0d data=%h pulses=1",
                             it, il, id, ni, dd_en ? 6 + 2 * s : 3 + s, ref_rd(ia));
                end
            end
            if (dd_en) begin
                n_cmp++;
                if (dl !== 3 + s || nd !== 1 || ns !== 1 || (!we && dd !== exp_d)) begin
                    n_bad++;
                    $display("FAIL rand%0d_data: got lat=%0d pulses=%0d stall_low=%0d data=%h want lat=%0d pulses=1 stall_low=1 data=%h (we=%b)",
                             it, dl, nd, ns, dd, 3 + s, exp_d, we);
                end
                n_cmp++;
                if (acc_q.size() < 1 || acc_q[0].addr !== da || acc_q[0].we !== we ||
                    (we && (acc_q[0].wd !== wd || acc_q[0].sel !== sel))) begin
                    n_bad++;
                    $display("FAIL rand%0d_data_mem_side: got n=%0d addr=%h we=%b want addr=%h we=%b wd=%h sel=%h",
                             it, acc_q.size(), acc_q.size() > 0 ? acc_q[0].addr : 32'h0,
                             acc_q.size() > 0 ? acc_q[0].we : 1'b0, da, we, wd, sel);
                end
            end
            if (di) begin
                n_cmp++;
                if (acc_q.size() < 1 || acc_q[acc_q.size()-1].addr !== ia ||
                    acc_q[acc_q.size()-1].we !== 1'b0 || acc_q[acc_q.size()-1].sel !== 4'hF) begin
                    n_bad++;
                    $display("FAIL rand%0d_fetch_mem_side: got n=%0d want last access addr=%h we=0 sel=f",
                             it, acc_q.size(), ia);
                end
            end
        end
        stall_cfg = 0;
    endtask

    task automatic test_reset_mid;
        int   n_dack = 0, n_iack = 0;
        logic st = 1'b1;
        int il, dl, ni, nd, ns; logic [31:0] id, dd; byte f;
        mdl_en = 1'b0; in_stb = 1'b0; ack_next = 1'b0;
        m_ack = 1'b0; m_stall = 1'b0;
        d_addr = 32'h700; d_wr_en = 1'b1; d_wr_data = 32'h1234_5678; d_wr_sel = 4'hF;
        d_cyc = 1'b1; d_stb = 1'b1;
        for (int c = 0; c < 20 && st; c++) begin
            @(negedge clk); st = d_stall;
            @(posedge clk); #1;
        end
        d_stb = 1'b0;
        n_cmp++; if (m_cyc !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_data: got m_cyc=%b want 1", m_cyc); end
        @(negedge clk); rst_n = 1'b0; #1;
        n_cmp++;
        if (m_cyc !== 1'b0 || m_stb !== 1'b0 || d_stall !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_async_clear: got m_cyc=%b m_stb=%b d_stall=%b want 0 0 1", m_cyc, m_stb, d_stall);
        end
        d_cyc = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); m_ack = 1'b1; m_rd_data = 32'hBAD0_BAD0;
        @(negedge clk); m_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (d_ack) n_dack++;
            if (instr_ack) n_iack++;
        end
        n_cmp++; if (n_dack !== 0 || n_iack !== 0) begin n_bad++; $display("FAIL rstmid_no_ack: got d=%0d i=%0d want 0/0", n_dack, n_iack); end
        n_cmp++; if (m_cyc !== 1'b0) begin n_bad++; $display("FAIL rstmid_m_cyc: got %b want 0", m_cyc); end
        @(posedge clk); #1;
        mdl_en = 1'b1;
        stall_cfg = 0;
        run_pair(1'b0, '0, 1'b1, 1'b0, 32'h704, '0, 4'hF, il, dl, id, dd, ni, nd, ns, f);
        n_cmp++;
        if (dl !== 3 || dd !== ref_rd(32'h704)) begin
            n_bad++; $display("FAIL rstmid_idle_after: got lat=%0d data=%h want 3 %h", dl, dd, ref_rd(32'h704));
        end
    endtask

    initial begin
        instr_stb = 1'b0; instr_addr = '0;
        d_cyc = 1'b0; d_stb = 1'b0; d_wr_en = 1'b0; d_addr = '0; d_wr_data = '0; d_wr_sel = '0;
        mem[32'h1000]     = 32'h0050_0093;
        ref_mem[32'h1000] = 32'h0050_0093;
        test_reset;
        test_lone_fetch;
        test_lone_write;
        test_simultaneous;
        test_stall;
        test_dcyc_drop;
        test_starve;
        test_random;
        test_reset_mid;
        n_cmp++;
        if (overlap !== 0) begin n_bad++; $display("FAIL ack_overlap: got %0d cycles with both acks want 0", overlap); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
